// File: rtl/ip_rx_serializer_pkg.sv
// Shared definitions for the RX serializer: FSM encodings, prefix size,
// protocol constant and the header sanity check.
package ip_rx_serializer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_PAY   = 3'd2,
    ST_PAD   = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DROP  = 3'd5
  } state_t;

  localparam int         PREFIX_BYTES    = 10;
  localparam logic [3:0] LAST_PREFIX_IDX = 4'(PREFIX_BYTES - 1);
  localparam logic [7:0] UDP_PROTOCOL    = 8'd17;

  // A header shorter than the minimum 5 words, or a total length that does
  // not even cover the header, cannot yield a meaningful payload length.
  function automatic logic hdr_malformed(input logic [3:0] ihl, input logic [15:0] ip_length);
    return (ihl < 4'd5) || (ip_length < {10'd0, ihl, 2'b00});
  endfunction

endpackage

// File: rtl/ip_rx_serializer_if.sv
// Bus bundle around the RX serializer: IP header handshake, AXI-Stream
// payload and the byte FIFO write port.
//   master : the surrounding system (IP stack + FIFO)
//   slave  : the serializer itself
interface ip_rx_serializer_if;
  logic        rx_hdr_valid;
  logic        rx_hdr_ready;
  logic [3:0]  rx_ip_ihl;
  logic [15:0] rx_ip_length;
  logic [7:0]  rx_ip_protocol;
  logic [31:0] rx_ip_source_ip;
  logic [31:0] rx_ip_dest_ip;
  logic [7:0]  rx_payload_tdata;
  logic        rx_payload_tvalid;
  logic        rx_payload_tready;
  logic        rx_payload_tlast;
  logic [7:0]  fifo_din;
  logic        fifo_full_n;
  logic        fifo_write;

  modport master (
    output rx_hdr_valid, rx_ip_ihl, rx_ip_length, rx_ip_protocol,
           rx_ip_source_ip, rx_ip_dest_ip,
           rx_payload_tdata, rx_payload_tvalid, rx_payload_tlast, fifo_full_n,
    input  rx_hdr_ready, rx_payload_tready, fifo_din, fifo_write
  );

  modport slave (
    input  rx_hdr_valid, rx_ip_ihl, rx_ip_length, rx_ip_protocol,
           rx_ip_source_ip, rx_ip_dest_ip,
           rx_payload_tdata, rx_payload_tvalid, rx_payload_tlast, fifo_full_n,
    output rx_hdr_ready, rx_payload_tready, fifo_din, fifo_write
  );
endinterface

// File: rtl/ip_rx_serializer.sv
// RX bridge: turns one IP header + AXI-Stream payload into a framed byte
// stream for the RX FIFO (src IP, dst IP, plen, then exactly plen bytes).
// Packets with another protocol or a malformed header are consumed and
// counted in drop_count.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : header/payload/FIFO bundle (slave modport)
//   drop_count  : saturating count of dropped packets
//
// state  | meaning
// IDLE   | waiting for a header, rx_hdr_ready high
// HDR    | writing the 10 prefix bytes
// PAY    | payload pass-through to the FIFO
// PAD    | payload ended early, filling the frame with zeros
// FLUSH  | frame complete, discarding the rest of the payload
// DROP   | filtered packet, discarding the payload
module ip_rx_serializer
  import ip_rx_serializer_pkg::*;
#(
  parameter logic [7:0] FILTER_PROTOCOL = UDP_PROTOCOL
) (
  input  logic                clk,
  input  logic                rst,
  ip_rx_serializer_if.slave   bus,
  output logic [15:0]         drop_count
);

  state_t      state, state_next;
  logic [3:0]  idx;
  logic [15:0] remaining;
  logic [31:0] src_ip, dst_ip;
  logic [15:0] plen;
  logic [7:0]  prefix_byte;
  logic        hdr_drop;

  assign hdr_drop = (bus.rx_ip_protocol != FILTER_PROTOCOL) ||
                    hdr_malformed(bus.rx_ip_ihl, bus.rx_ip_length);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:
        if (bus.rx_hdr_valid) state_next = hdr_drop ? ST_DROP : ST_HDR;
      ST_HDR:
        if (bus.fifo_full_n && idx == LAST_PREFIX_IDX)
          state_next = (plen == 16'd0) ? ST_FLUSH : ST_PAY;
      ST_PAY:
        if (bus.rx_payload_tvalid && bus.fifo_full_n) begin
          if (remaining == 16'd1)     state_next = bus.rx_payload_tlast ? ST_IDLE : ST_FLUSH;
          else if (bus.rx_payload_tlast) state_next = ST_PAD;
        end
      ST_PAD:
        if (bus.fifo_full_n && remaining == 16'd1) state_next = ST_IDLE;
      ST_FLUSH, ST_DROP:
        if (bus.rx_payload_tvalid && bus.rx_payload_tlast) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    case (idx)
      4'd0:    prefix_byte = src_ip[31:24];
      4'd1:    prefix_byte = src_ip[23:16];
      4'd2:    prefix_byte = src_ip[15:8];
      4'd3:    prefix_byte = src_ip[7:0];
      4'd4:    prefix_byte = dst_ip[31:24];
      4'd5:    prefix_byte = dst_ip[23:16];
      4'd6:    prefix_byte = dst_ip[15:8];
      4'd7:    prefix_byte = dst_ip[7:0];
      4'd8:    prefix_byte = plen[15:8];
      4'd9:    prefix_byte = plen[7:0];
      default: prefix_byte = 8'h00;
    endcase
  end

  always_comb begin
    bus.rx_hdr_ready      = 1'b0;
    bus.rx_payload_tready = 1'b0;
    bus.fifo_din          = 8'h00;
    bus.fifo_write        = 1'b0;
    case (state)
      ST_IDLE: bus.rx_hdr_ready = 1'b1;
      ST_HDR: begin
        bus.fifo_din   = prefix_byte;
        bus.fifo_write = bus.fifo_full_n;
      end
      ST_PAY: begin
        bus.rx_payload_tready = bus.fifo_full_n;
        bus.fifo_din          = bus.rx_payload_tdata;
        bus.fifo_write        = bus.rx_payload_tvalid && bus.fifo_full_n;
      end
      ST_PAD:            bus.fifo_write = bus.fifo_full_n;
      ST_FLUSH, ST_DROP: bus.rx_payload_tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ip     <= '0;
      dst_ip     <= '0;
      plen       <= '0;
      idx        <= '0;
      remaining  <= '0;
      drop_count <= '0;
    end else begin
      if (state == ST_IDLE && bus.rx_hdr_valid) begin
        src_ip <= bus.rx_ip_source_ip;
        dst_ip <= bus.rx_ip_dest_ip;
        plen   <= bus.rx_ip_length - {10'd0, bus.rx_ip_ihl, 2'b00};
        idx    <= 4'd0;
        if (hdr_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (state == ST_HDR && bus.fifo_full_n) begin
        idx <= idx + 4'd1;
        if (idx == LAST_PREFIX_IDX) remaining <= plen;
      end
      // Remaining counts frame bytes still owed, whether from payload or padding.
      if ((state == ST_PAY && bus.rx_payload_tvalid && bus.fifo_full_n) ||
          (state == ST_PAD && bus.fifo_full_n))
        remaining <= remaining - 16'd1;
    end
  end

endmodule

// File: tb/tb_ip_rx_serializer.sv
`timescale 1ns/1ps
module tb_ip_rx_serializer;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] drop_count;

  ip_rx_serializer_if ifc();

  ip_rx_serializer #(.FILTER_PROTOCOL(8'd17)) dut (
    .clk(clk), .rst(rst), .bus(ifc), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   passes = 0;
  bq_t  exp_q;
  int   exp_drops = 0;
  int   full_mode = 0;  // 0: never full, 1: toggle each cycle, 2: random

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every FIFO write is checked against the model queue.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && ifc.fifo_write) begin
      check("write_while_full", {31'd0, ifc.fifo_full_n}, 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got byte %02h, expected no write", ifc.fifo_din);
      end else begin
        e = exp_q.pop_front();
        check("fifo_byte", {24'd0, ifc.fifo_din}, {24'd0, e});
      end
    end
  end

  initial begin
    ifc.fifo_full_n = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (full_mode)
        0:       ifc.fifo_full_n = 1'b1;
        1:       ifc.fifo_full_n = ~ifc.fifo_full_n;
        default: ifc.fifo_full_n = ($urandom_range(3) != 0);
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: frame = src(4) dst(4) plen(2) then plen bytes, taken
  // from the payload and zero-filled if the payload is short.
  task automatic model_pkt(input logic [7:0] proto, input logic [3:0] ihl, input logic [15:0] len,
                           input logic [31:0] src, input logic [31:0] dst, input bq_t pay);
    int hdr_bytes;
    int plen;
    hdr_bytes = int'(ihl) * 4;
    if (proto != 8'd17 || ihl < 4'd5 || int'(len) < hdr_bytes) begin
      if (exp_drops < 65535) exp_drops++;
      return;
    end
    plen = int'(len) - hdr_bytes;
    for (int s = 24; s >= 0; s -= 8) exp_q.push_back(8'((src >> s) & 32'hFF));
    for (int s = 24; s >= 0; s -= 8) exp_q.push_back(8'((dst >> s) & 32'hFF));
    exp_q.push_back(8'(plen / 256));
    exp_q.push_back(8'(plen % 256));
    for (int i = 0; i < plen; i++) exp_q.push_back(i < pay.size() ? pay[i] : 8'h00);
  endtask

  task automatic send_hdr(input logic [7:0] proto, input logic [3:0] ihl, input logic [15:0] len,
                          input logic [31:0] src, input logic [31:0] dst);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    ifc.rx_hdr_valid    = 1'b1;
    ifc.rx_ip_protocol  = proto;
    ifc.rx_ip_ihl       = ihl;
    ifc.rx_ip_length    = len;
    ifc.rx_ip_source_ip = src;
    ifc.rx_ip_dest_ip   = dst;
    while (!ok && n < 3000) begin
      @(negedge clk);
      ok = ifc.rx_hdr_ready;
      @(posedge clk); #1;
      n++;
    end
    ifc.rx_hdr_valid = 1'b0;
    if (!ok) begin
      checks++;
      $display("FAIL hdr_timeout: got no rx_hdr_ready in %0d cycles, expected accept", n);
    end
  endtask

  task automatic send_payload(input bq_t pay, input bit gaps);
    int n;
    bit ok;
    for (int i = 0; i < pay.size(); i++) begin
      if (gaps && $urandom_range(3) == 0) begin
        ifc.rx_payload_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      ifc.rx_payload_tvalid = 1'b1;
      ifc.rx_payload_tdata  = pay[i];
      ifc.rx_payload_tlast  = (i == pay.size() - 1);
      n = 0;
      ok = 1'b0;
      while (!ok && n < 3000) begin
        @(negedge clk);
        ok = ifc.rx_payload_tready;
        @(posedge clk); #1;
        n++;
      end
      if (!ok) begin
        checks++;
        $display("FAIL beat_timeout: beat %0d not accepted in %0d cycles, expected accept", i, n);
        break;
      end
    end
    ifc.rx_payload_tvalid = 1'b0;
    ifc.rx_payload_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] proto, input logic [3:0] ihl, input logic [15:0] len,
                          input logic [31:0] src, input logic [31:0] dst, input bq_t pay, input bit gaps);
    model_pkt(proto, ihl, len, src, dst, pay);
    send_hdr(proto, ihl, len, src, dst);
    send_payload(pay, gaps);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !ifc.rx_hdr_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_idle"}, {31'd0, ifc.rx_hdr_ready}, 32'd1);
    check({name, "_drop_count"}, {16'd0, drop_count}, exp_drops);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  function automatic bq_t seq_bytes(input int n, input int first);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'(first + i));
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255)));
    return q;
  endfunction

  localparam logic [31:0] SRC = 32'hC0A8017B;
  localparam logic [31:0] DST = 32'hC0A80180;

  initial begin
    logic [7:0]  proto;
    logic [3:0]  ihl;
    logic [15:0] len;
    int          plen;
    int          nbeats;

    rst = 1'b1;
    ifc.rx_hdr_valid      = 1'b0;
    ifc.rx_ip_ihl         = '0;
    ifc.rx_ip_length      = '0;
    ifc.rx_ip_protocol    = '0;
    ifc.rx_ip_source_ip   = '0;
    ifc.rx_ip_dest_ip     = '0;
    ifc.rx_payload_tdata  = '0;
    ifc.rx_payload_tvalid = 1'b0;
    ifc.rx_payload_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hdr_ready", {31'd0, ifc.rx_hdr_ready}, 32'd1);
    check("rst_tready", {31'd0, ifc.rx_payload_tready}, 32'd0);
    check("rst_fifo_write", {31'd0, ifc.fifo_write}, 32'd0);
    check("rst_fifo_din", {24'd0, ifc.fifo_din}, 32'd0);
    check("rst_drop_count", {16'd0, drop_count}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send_pkt(8'd17, 4'd5, 16'd28, SRC, DST, seq_bytes(8, 1), 1'b0);
    wait_idle("normal");
    send_pkt(8'd6, 4'd5, 16'd40, SRC, DST, seq_bytes(20, 8'h40), 1'b0);
    wait_idle("non_udp");
    send_pkt(8'd17, 4'd5, 16'd28, SRC, DST, seq_bytes(5, 1), 1'b0);
    wait_idle("short");
    send_pkt(8'd17, 4'd5, 16'd28, SRC, DST, seq_bytes(12, 1), 1'b0);
    wait_idle("long");
    full_mode = 1;
    send_pkt(8'd17, 4'd5, 16'd28, SRC, DST, seq_bytes(8, 1), 1'b0);
    wait_idle("backpressure");
    full_mode = 0;
    send_pkt(8'd17, 4'd5, 16'd20, SRC, DST, seq_bytes(3, 8'h90), 1'b0);
    wait_idle("zero_plen");
    send_pkt(8'd17, 4'd5, 16'd10, SRC, DST, seq_bytes(1, 8'hA0), 1'b0);
    wait_idle("malformed_len");
    send_pkt(8'd17, 4'd4, 16'd28, SRC, DST, seq_bytes(4, 8'hB0), 1'b0);
    wait_idle("malformed_ihl");

    // Reset after three prefix bytes: only those three may appear.
    @(posedge clk); #1;
    for (int s = 24; s >= 8; s -= 8) exp_q.push_back(8'((SRC >> s) & 32'hFF));
    send_hdr(8'd17, 4'd5, 16'd28, SRC, DST);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_drops = 0;
    #1;
    check("midrst_prefix_seen", exp_q.size(), 0);
    check("midrst_hdr_ready", {31'd0, ifc.rx_hdr_ready}, 32'd1);
    check("midrst_tready", {31'd0, ifc.rx_payload_tready}, 32'd0);
    check("midrst_fifo_write", {31'd0, ifc.fifo_write}, 32'd0);
    check("midrst_drop_count", {16'd0, drop_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_pkt(8'd17, 4'd5, 16'd28, SRC, DST, seq_bytes(8, 1), 1'b0);
    wait_idle("after_reset");

    // Randomized back-to-back traffic.
    for (int k = 0; k < 40; k++) begin
      full_mode = $urandom_range(2);
      proto = ($urandom_range(4) == 0) ? 8'($urandom_range(255)) : 8'd17;
      ihl   = ($urandom_range(9) == 0) ? 4'($urandom_range(4)) : 4'(5 + $urandom_range(2));
      plen  = $urandom_range(24);
      len   = 16'(int'(ihl) * 4 + plen);
      if ($urandom_range(9) == 0) len = 16'($urandom_range(30));
      nbeats = 1 + $urandom_range(plen + 4);
      send_pkt(proto, ihl, len, $urandom, $urandom, rand_bytes(nbeats), ($urandom_range(1) == 1));
    end
    wait_idle("random");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
